// File: rtl/lot_checker_n_pkg.sv
// Shared types and constants for the parametrised lottery-ticket checker.
package lot_pkg;

  typedef enum logic [1:0] {COLLECT, READY, SHOW} state_t;

  localparam logic [1:0] PREMIO_NONE = 2'b00;
  localparam logic [1:0] PREMIO_1    = 2'b01;
  localparam logic [1:0] PREMIO_2    = 2'b10;

  typedef logic [3:0] bcd_t;

  function automatic logic bcd_valid(input bcd_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/lot_checker_n_if.sv
// Digit/strobe inputs and grade/tally outputs of the lottery-ticket checker.
interface lot_checker_n_if #(
  parameter int N_DIG = 5,
  parameter int CNT_W = 5
);
  import lot_pkg::*;

  bcd_t               num;
  logic               insere;
  logic               fim;
  logic               fim_jogo;
  logic               win_load;
  logic [4*N_DIG-1:0] win_in;
  logic [1:0]         premio;
  logic [CNT_W-1:0]   p1;
  logic [CNT_W-1:0]   p2;
  logic               pronto;
  logic               mostra;
  logic               erro;

  modport master (
    output num, insere, fim, fim_jogo, win_load, win_in,
    input  premio, p1, p2, pronto, mostra, erro
  );

  modport slave (
    input  num, insere, fim, fim_jogo, win_load, win_in,
    output premio, p1, p2, pronto, mostra, erro
  );
endinterface

// File: rtl/lot_checker_n_run_tracker.sv
// Tracks the current and longest run of consecutive matching digits.
module lot_run_tracker #(
  parameter int N_DIG = 5,
  parameter int RUN_W = $clog2(N_DIG + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             strobe,
  input  logic             match,
  output logic [RUN_W-1:0] run_max
);
  logic [RUN_W-1:0] run_cur;
  logic [RUN_W-1:0] run_nxt;

  assign run_nxt = match ? run_cur + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      run_cur <= '0;
      run_max <= '0;
    end else if (strobe) begin
      run_cur <= run_nxt;
      if (run_nxt > run_max) run_max <= run_nxt;
    end
  end
endmodule

// File: rtl/lot_checker_n.sv
// Lottery-ticket checker: positional digit compare, longest-run grading,
// saturating per-tier tallies and a run-time loadable winning number.
module lot_checker_n
  import lot_pkg::*;
#(
  parameter int                 N_DIG       = 5,
  parameter int                 CNT_W       = 5,
  parameter int                 P1_RUN      = 4,
  parameter int                 P2_RUN      = 2,
  parameter logic [4*N_DIG-1:0] WIN_DEFAULT = 'h47019
) (
  input logic             clk,
  input logic             reset,
  lot_checker_n_if.slave  bus
);
  localparam int IDX_W = $clog2(N_DIG);
  localparam int RUN_W = $clog2(N_DIG + 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [4*N_DIG-1:0] win_reg;
  logic [1:0]         premio;
  logic [CNT_W-1:0]   p1, p2;
  logic               pronto, mostra, erro;

  bcd_t             cur_win;
  logic             win_ok, take_load, take_fim, take_digit, match;
  logic [RUN_W-1:0] run_max;
  logic [1:0]       tier;

  always_comb begin
    cur_win = '0;
    for (int i = 0; i < N_DIG; i++)
      if (idx == IDX_W'(i)) cur_win = win_reg[4*(N_DIG-1-i) +: 4];
    win_ok = 1'b1;
    for (int i = 0; i < N_DIG; i++)
      if (!bcd_valid(bus.win_in[4*i +: 4])) win_ok = 1'b0;
  end

  // An accepted load consumes the cycle; a rejected one lets fim/insere through.
  assign take_load  = bus.win_load && state == COLLECT && idx == '0 && win_ok;
  assign take_fim   = !take_load && bus.fim && state == READY;
  assign take_digit = !take_load && bus.insere && state == COLLECT;
  assign match      = bcd_valid(bus.num) && bus.num == cur_win;

  assign tier = (run_max >= RUN_W'(P1_RUN)) ? PREMIO_1 :
                (run_max >= RUN_W'(P2_RUN)) ? PREMIO_2 : PREMIO_NONE;

  lot_run_tracker #(.N_DIG(N_DIG), .RUN_W(RUN_W)) u_run (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.fim_jogo),
    .strobe  (take_digit && !bus.fim_jogo),
    .match   (match),
    .run_max (run_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= COLLECT;
      idx     <= '0;
      win_reg <= WIN_DEFAULT;
      premio  <= PREMIO_NONE;
      p1      <= '0;
      p2      <= '0;
      pronto  <= 1'b0;
      mostra  <= 1'b0;
      erro    <= 1'b0;
    end else if (bus.fim_jogo) begin
      state  <= COLLECT;
      idx    <= '0;
      premio <= PREMIO_NONE;
      pronto <= 1'b0;
      mostra <= 1'b0;
      erro   <= 1'b0;
    end else if (take_load) begin
      win_reg <= bus.win_in;
    end else if (take_fim) begin
      premio <= tier;
      if (tier == PREMIO_1 && p1 != '1) p1 <= p1 + 1'b1;
      if (tier == PREMIO_2 && p2 != '1) p2 <= p2 + 1'b1;
      state  <= SHOW;
      pronto <= 1'b0;
      mostra <= 1'b1;
    end else if (take_digit) begin
      if (!bcd_valid(bus.num)) erro <= 1'b1;
      if (idx == IDX_W'(N_DIG - 1)) begin
        idx    <= '0;
        state  <= READY;
        pronto <= 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.premio = premio;
  assign bus.p1     = p1;
  assign bus.p2     = p2;
  assign bus.pronto = pronto;
  assign bus.mostra = mostra;
  assign bus.erro   = erro;
endmodule

// File: tb/tb_lot_checker_n.sv
// Bench for lot_checker_n: directed scenarios plus randomized traffic
// against a ticket-level reference model; a second instance has 2-bit tallies.
module tb_lot_checker_n;
  localparam int N_DIG = 5;
  localparam int CNT_W = 5;
  localparam int SAT_W = 2;
  localparam logic [4*N_DIG-1:0] WIN_DEF = 'h47019;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] num = '0;
  logic insere = 1'b0, fim = 1'b0, fim_jogo = 1'b0, win_load = 1'b0;
  logic [4*N_DIG-1:0] win_in = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lot_checker_n_if #(.N_DIG(N_DIG), .CNT_W(CNT_W)) bus ();
  lot_checker_n_if #(.N_DIG(N_DIG), .CNT_W(SAT_W)) bus_s ();

  assign bus.num = num;        assign bus_s.num = num;
  assign bus.insere = insere;  assign bus_s.insere = insere;
  assign bus.fim = fim;        assign bus_s.fim = fim;
  assign bus.fim_jogo = fim_jogo; assign bus_s.fim_jogo = fim_jogo;
  assign bus.win_load = win_load; assign bus_s.win_load = win_load;
  assign bus.win_in = win_in;  assign bus_s.win_in = win_in;

  lot_checker_n #(.N_DIG(N_DIG), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));
  lot_checker_n #(.N_DIG(N_DIG), .CNT_W(SAT_W)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  logic [2+2*CNT_W+2:0] act_m;
  logic [2+2*SAT_W+2:0] act_s;
  assign act_m = {bus.premio, bus.p1, bus.p2, bus.pronto, bus.mostra, bus.erro};
  assign act_s = {bus_s.premio, bus_s.p1, bus_s.p2, bus_s.pronto, bus_s.mostra, bus_s.erro};

  // Reference model: a ticket is a list of digits graded when complete.
  int m_win[N_DIG];
  int m_tkt[$];
  bit m_ready, m_show, m_erro;
  logic [1:0] m_premio;
  int m_p1, m_p2;

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [2+2*CNT_W+2:0] exp_m();
    return {m_premio, CNT_W'(sat(m_p1, CNT_W)), CNT_W'(sat(m_p2, CNT_W)), m_ready, m_show, m_erro};
  endfunction

  function automatic logic [2+2*SAT_W+2:0] exp_s();
    return {m_premio, SAT_W'(sat(m_p1, SAT_W)), SAT_W'(sat(m_p2, SAT_W)), m_ready, m_show, m_erro};
  endfunction

  function automatic void set_win(input logic [4*N_DIG-1:0] w);
    for (int i = 0; i < N_DIG; i++) m_win[i] = int'((w >> (4*(N_DIG-1-i))) & 'hF);
  endfunction

  function automatic void model_edge();
    bit ok;
    int cur, best;
    if (reset) begin
      m_tkt.delete(); m_ready = 0; m_show = 0; m_erro = 0;
      m_premio = 2'b00; m_p1 = 0; m_p2 = 0; set_win(WIN_DEF);
      return;
    end
    if (fim_jogo) begin
      m_tkt.delete(); m_ready = 0; m_show = 0; m_erro = 0; m_premio = 2'b00;
      return;
    end
    ok = 1;
    for (int i = 0; i < N_DIG; i++) if (((win_in >> (4*i)) & 'hF) > 9) ok = 0;
    if (win_load && ok && !m_ready && !m_show && m_tkt.size() == 0) begin
      set_win(win_in);
    end else if (fim && m_ready) begin
      cur = 0; best = 0;
      for (int i = 0; i < N_DIG; i++) begin
        if (m_tkt[i] <= 9 && m_tkt[i] == m_win[i]) cur++; else cur = 0;
        if (cur > best) best = cur;
      end
      if (best >= 4) begin m_premio = 2'b01; m_p1++; end
      else if (best >= 2) begin m_premio = 2'b10; m_p2++; end
      else m_premio = 2'b00;
      m_ready = 0; m_show = 1;
    end else if (insere && !m_ready && !m_show) begin
      m_tkt.push_back(int'(num));
      if (num > 9) m_erro = 1;
      if (m_tkt.size() == N_DIG) m_ready = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic put(input int d);
    num = 4'(d); insere = 1'b1; tick(); insere = 1'b0;
  endtask

  task automatic put_all(input logic [4*N_DIG-1:0] t);
    for (int i = 0; i < N_DIG; i++) put(int'((t >> (4*(N_DIG-1-i))) & 'hF));
  endtask

  task automatic pulse_fim();   fim = 1'b1; tick(); fim = 1'b0; endtask
  task automatic pulse_jogo();  fim_jogo = 1'b1; tick(); fim_jogo = 1'b0; endtask
  task automatic load_win(input logic [4*N_DIG-1:0] w);
    win_in = w; win_load = 1'b1; tick(); win_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_cmp++;
    if (act_m !== {2'b00, 10'd0, 3'b000}) begin
      n_bad++; $display("FAIL reset_main: got %h want %h", act_m, {2'b00, 10'd0, 3'b000});
    end
    n_cmp++;
    if (act_s !== exp_s()) begin n_bad++; $display("FAIL reset_sat: got %h want %h", act_s, exp_s()); end
  endtask

  task automatic test_prize1();
    put_all('h47019);
    n_cmp++;
    if (bus.pronto !== 1'b1) begin n_bad++; $display("FAIL p1_pronto: got %b want 1", bus.pronto); end
    pulse_fim();
    n_cmp++;
    if ({bus.premio, bus.p1, bus.p2, bus.mostra} !== {2'b01, 5'd1, 5'd0, 1'b1}) begin
      n_bad++; $display("FAIL prize1: got %b/%0d/%0d/%b want 01/1/0/1", bus.premio, bus.p1, bus.p2, bus.mostra);
    end
    n_cmp++;
    if (act_m !== exp_m()) begin n_bad++; $display("FAIL prize1_model: got %h want %h", act_m, exp_m()); end
  endtask

  task automatic test_prize2();
    pulse_jogo();
    put_all('h47055);
    pulse_fim();
    n_cmp++;
    if ({bus.premio, bus.p1, bus.p2} !== {2'b10, 5'd1, 5'd1}) begin
      n_bad++; $display("FAIL prize2: got %b/%0d/%0d want 10/1/1", bus.premio, bus.p1, bus.p2);
    end
  endtask

  task automatic test_no_prize_early_fim();
    pulse_jogo();
    put(1); put(2); put(0);
    pulse_fim();
    n_cmp++;
    if ({bus.pronto, bus.mostra} !== 2'b00) begin
      n_bad++; $display("FAIL early_fim: got pronto=%b mostra=%b want 0 0", bus.pronto, bus.mostra);
    end
    put(5); put(9);
    pulse_fim();
    n_cmp++;
    if ({bus.premio, bus.p1, bus.p2, bus.mostra} !== {2'b00, 5'd1, 5'd1, 1'b1}) begin
      n_bad++; $display("FAIL no_prize: got %b/%0d/%0d/%b want 00/1/1/1", bus.premio, bus.p1, bus.p2, bus.mostra);
    end
  endtask

  task automatic test_saturation();
    int want_s[4] = '{1, 2, 3, 3};
    reset = 1'b1; tick(); reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      pulse_jogo();
      put_all('h47019);
      pulse_fim();
      n_cmp++;
      if ({bus_s.premio, bus_s.p1} !== {2'b01, 2'(want_s[r])}) begin
        n_bad++; $display("FAIL sat_round%0d: got %b/%0d want 01/%0d", r, bus_s.premio, bus_s.p1, want_s[r]);
      end
      n_cmp++;
      if (bus.p1 !== 5'(r + 1)) begin
        n_bad++; $display("FAIL sat_main%0d: got %0d want %0d", r, bus.p1, r + 1);
      end
    end
  endtask

  task automatic test_win_load();
    pulse_jogo();
    load_win('h12345);
    put_all('h12345);
    pulse_fim();
    n_cmp++;
    if (bus.premio !== 2'b01) begin n_bad++; $display("FAIL load_ok: got %b want 01", bus.premio); end
    pulse_jogo();
    put(1); put(2);
    load_win('h99999);
    put(3); put(4); put(5);
    pulse_fim();
    n_cmp++;
    if (bus.premio !== 2'b01) begin n_bad++; $display("FAIL load_midticket: got %b want 01", bus.premio); end
    pulse_jogo();
    load_win('h1A345);
    put_all('h12345);
    pulse_fim();
    n_cmp++;
    if (bus.premio !== 2'b01) begin n_bad++; $display("FAIL load_nonbcd: got %b want 01", bus.premio); end
    n_cmp++;
    if (act_m !== exp_m()) begin n_bad++; $display("FAIL load_model: got %h want %h", act_m, exp_m()); end
  endtask

  task automatic test_invalid_and_reset();
    pulse_jogo();
    load_win('h47019);
    put(4); put('hA);
    n_cmp++;
    if (bus.erro !== 1'b1) begin n_bad++; $display("FAIL erro_set: got %b want 1", bus.erro); end
    put(0);
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++;
    if ({bus.erro, bus.p1, bus.p2, bus.pronto} !== {1'b0, 5'd0, 5'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset_mid: got erro=%b p1=%0d p2=%0d pronto=%b want 0 0 0 0",
                        bus.erro, bus.p1, bus.p2, bus.pronto);
    end
    put_all('h47019);
    pulse_fim();
    n_cmp++;
    if ({bus.premio, bus.p1} !== {2'b01, 5'd1}) begin
      n_bad++; $display("FAIL reset_winreg: got %b/%0d want 01/1", bus.premio, bus.p1);
    end
    pulse_jogo();
    put_all('h47A19);
    pulse_fim();
    n_cmp++;
    if ({bus.premio, bus.erro, bus.p2} !== {2'b10, 1'b1, 5'd1}) begin
      n_bad++; $display("FAIL bad_digit_mismatch: got %b/%b/%0d want 10/1/1", bus.premio, bus.erro, bus.p2);
    end
  endtask

  task automatic test_random();
    int r, pos;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 2) reset = 1'b1;
      else if (r < 40) fim_jogo = 1'b1;
      else if (r < 80) begin
        win_load = 1'b1;
        for (int i = 0; i < N_DIG; i++) win_in[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 3) == 0) win_in[4*$urandom_range(0, N_DIG-1) +: 4] = 4'($urandom_range(10, 15));
      end else begin
        insere = ($urandom_range(0, 9) < 6);
        fim = ($urandom_range(0, 9) < 3);
        pos = m_tkt.size();
        if (pos < N_DIG && $urandom_range(0, 9) < 7) num = 4'(m_win[pos]);
        else num = 4'($urandom_range(0, 15));
      end
      tick();
      reset = 1'b0; fim_jogo = 1'b0; win_load = 1'b0; insere = 1'b0; fim = 1'b0;
      n_cmp++;
      if (act_m !== exp_m()) begin n_bad++; $display("FAIL rand_main c%0d: got %h want %h", c, act_m, exp_m()); end
      n_cmp++;
      if (act_s !== exp_s()) begin n_bad++; $display("FAIL rand_sat c%0d: got %h want %h", c, act_s, exp_s()); end
    end
  endtask

  initial begin
    test_reset();
    test_prize1();
    test_prize2();
    test_no_prize_early_fim();
    test_saturation();
    test_win_load();
    test_invalid_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lot_checker_n.md
Name: lot_checker_n

Overview:
Parametrised lottery-ticket checker, the successor of the fixed 5-digit checker.
- Accepts a ticket one BCD digit per `insere` strobe and compares each digit positionally against a winning number.
- Grades the ticket by the longest run of consecutive matching digits.
- Keeps saturating win tallies per prize tier.
- New relative to the previous generation: configurable digit count and tier thresholds, a run-time loadable winning number, and invalid-digit flagging.
- Sits between the keypad/digit front end and the display/score logic.

Parameters:
- N_DIG, 5, number of ticket digits (>=2).
- CNT_W, 5, width of the p1/p2 win counters.
- P1_RUN, 4, minimum longest-run length for prize 1 (P2_RUN < P1_RUN <= N_DIG).
- P2_RUN, 2, minimum longest-run length for prize 2 (>=1).
- WIN_DEFAULT, 'h47019, reset value of the winning number, N_DIG BCD nibbles, most significant nibble = first digit.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- num  in  4  BCD digit being inserted.
- insere  in  1  digit strobe, one digit per cycle high.
- fim  in  1  request grading of a complete ticket.
- fim_jogo  in  1  end of round; clears round state, keeps tallies.
- win_load  in  1  load a new winning number.
- win_in  in  4*N_DIG  new winning number, BCD.
- premio  out  2  grade: 01 = prize 1, 10 = prize 2, 00 = none.
- p1  out  CNT_W  prize-1 tally, saturating.
- p2  out  CNT_W  prize-2 tally, saturating.
- pronto  out  1  all N_DIG digits received, awaiting `fim`.
- mostra  out  1  result valid and held.
- erro  out  1  sticky: a non-BCD digit (>9) was inserted this round.

Behaviour:
- Fully synchronous, single clock. Input priority each cycle: reset > fim_jogo > win_load > fim > insere.
- Reset (synchronous):
  - state = COLLECT, idx = 0, run_cur = run_max = 0.
  - premio = 00, p1 = p2 = 0, erro = 0, pronto = 0, mostra = 0.
  - winning register = WIN_DEFAULT.
- Widths:
  - idx is clog2(N_DIG) bits.
  - run_cur and run_max are clog2(N_DIG+1) bits.
  - p1/p2 saturate at all-ones; a saturated counter holds its value while premio is still driven.
- COLLECT state (pronto = 0, mostra = 0), on `insere`:
  - match = (num == win[idx]) and num <= 9.
  - run_cur' = match ? run_cur+1 : 0.
  - run_max' = max(run_max, run_cur').
  - num > 9 sets erro and counts as a mismatch.
  - idx increments. The insert with idx == N_DIG-1 moves to READY next cycle, with idx = 0 and pronto = 1.
  - `fim` in COLLECT is ignored (incomplete ticket).
- READY state (pronto = 1):
  - `insere` is ignored.
  - On `fim`: tier = (run_max >= P1_RUN) ? 01 : (run_max >= P2_RUN) ? 10 : 00.
  - In the same edge: premio <= tier, the matching counter increments, state goes to SHOW. premio is valid the cycle after `fim`.
- SHOW state (mostra = 1):
  - premio and the tallies are held.
  - `insere`, `fim` and `win_load` are ignored.
- fim_jogo, in any state:
  - Next state COLLECT; idx, run_cur, run_max, premio, erro, pronto and mostra are cleared.
  - p1, p2 and the winning register are kept.
- win_load:
  - Accepted only in COLLECT with idx == 0 (no ticket in progress) and every nibble of win_in <= 9.
  - Otherwise ignored without side effects.
  - Takes effect for digits inserted from the next cycle.
- Simultaneous events:
  - Last-digit `insere` together with `fim`: the digit is accepted and `fim` is dropped.
  - `fim_jogo` together with `fim` in READY: no grading, no tally change.
  - reset in mid-ticket discards the partial ticket.

Decomposition:
- Shared package lot_pkg holds:
  - state enum {COLLECT, READY, SHOW};
  - premio encoding constants PREMIO_NONE = 2'b00, PREMIO_1 = 2'b01, PREMIO_2 = 2'b10;
  - 4-bit BCD digit typedef;
  - BCD-valid helper function.
- One sub-module, lot_run_tracker: takes match, strobe and clear, and holds run_cur/run_max. The top module keeps the FSM, the winning register, the digit select and the tallies.

Test Plan:
1. Default parameters, reset, digits 4,7,0,1,9, then `fim` -> premio = 01, p1 = 1, p2 = 0, mostra = 1.
2. fim_jogo, then digits 4,7,0,5,5, then `fim` -> run_max = 3, premio = 10, p1 = 1, p2 = 1.
3. fim_jogo, then digits 1,2,0,5,9, then `fim` -> run_max = 1, premio = 00, tallies unchanged. Also `fim` pulsed after 3 digits -> ignored, pronto stays 0.
4. Saturation:
   - Setup: CNT_W = 2.
   - Stimulus: four rounds of 4,7,0,1,9, then `fim`.
   - Expected: p1 = 1, 2, 3, 3; premio = 01 each round.
5. Winning-number load:
   - win_load with 'h12345 at idle, then 1,2,3,4,5 -> premio = 01.
   - win_load with 'h99999 after 2 digits -> ignored.
   - win_in 'h1A345 -> rejected.
6. Invalid digit: insert 4, then num = 'hA -> erro = 1, counted as a mismatch. Then reset after 3 digits -> idx = 0, p1 = p2 = 0, winning register = 'h47019.
